// File: rtl/bank_timer.sv
// Programmable 16-bit interval timer with an 8-bit prescaler and a maskable,
// registered active-low interrupt, mapped as eight byte registers on the CPU bus.
module bank_timer #(
    parameter logic [15:0] RESET_RELOAD   = 16'hFFFF,
    parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       R_W_n,
    input  logic [2:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_n_o
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_RELOAD_L = 3'd2;
    localparam logic [2:0] A_RELOAD_H = 3'd3;
    localparam logic [2:0] A_COUNT_L  = 3'd4;
    localparam logic [2:0] A_COUNT_H  = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;

    logic        en_q, en_d;
    logic        oneshot_q, oneshot_d;
    logic        ie_q, ie_d;
    logic        tf_q, tf_d;
    logic        irq_n_q, irq_n_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  shadow_q, shadow_d;

    logic wr_en;
    logic rd_en;
    logic wr_ctrl;
    logic load;
    logic tick;
    logic zero_hit;
    logic tf_clr;

    assign wr_en    = cs_i & ~R_W_n;
    assign rd_en    = cs_i & R_W_n;
    assign wr_ctrl  = wr_en && (addr_i == A_CTRL);
    assign load     = wr_ctrl & data_i[3];
    assign tick     = en_q && (pcnt_q == 8'd0);
    // LOAD takes priority over a tick landing on the same edge, so it also masks the expiry.
    assign zero_hit = tick && (count_q == 16'd0) && !load;
    assign tf_clr   = wr_en && (addr_i == A_STATUS) && data_i[0];

    always_comb begin
        en_d       = en_q;
        oneshot_d  = oneshot_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        shadow_d   = shadow_q;

        if (wr_ctrl) begin
            en_d      = data_i[0];
            oneshot_d = data_i[1];
            ie_d      = data_i[2];
        end else if (zero_hit && oneshot_q) begin
            en_d = 1'b0;
        end

        if (wr_en && (addr_i == A_PRESCALE)) prescale_d     = data_i;
        if (wr_en && (addr_i == A_RELOAD_L)) reload_d[7:0]  = data_i;
        if (wr_en && (addr_i == A_RELOAD_H)) reload_d[15:8] = data_i;

        // Reading the low byte snapshots the high byte for a tear-free 16-bit read.
        if (rd_en && (addr_i == A_COUNT_L)) shadow_d = count_q[15:8];
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = prescale_q;
        end else if (tick) begin
            pcnt_d = prescale_q;
        end else if (en_q) begin
            pcnt_d = pcnt_q - 8'd1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = reload_q;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (!oneshot_q) begin
                count_d = reload_q;
            end
        end
    end

    // A tick-driven set beats a simultaneous write-one-to-clear.
    always_comb begin
        tf_d    = (tf_q & ~tf_clr) | zero_hit;
        irq_n_d = ~(tf_q & ie_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            ie_q       <= 1'b0;
            tf_q       <= 1'b0;
            irq_n_q    <= 1'b1;
            prescale_q <= RESET_PRESCALE;
            pcnt_q     <= RESET_PRESCALE;
            reload_q   <= RESET_RELOAD;
            count_q    <= RESET_RELOAD;
            shadow_q   <= 8'h00;
        end else begin
            en_q       <= en_d;
            oneshot_q  <= oneshot_d;
            ie_q       <= ie_d;
            tf_q       <= tf_d;
            irq_n_q    <= irq_n_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (cs_i) begin
            case (addr_i)
                A_CTRL:     data_o = {5'b0, ie_q, oneshot_q, en_q};
                A_PRESCALE: data_o = prescale_q;
                A_RELOAD_L: data_o = reload_q[7:0];
                A_RELOAD_H: data_o = reload_q[15:8];
                A_COUNT_L:  data_o = count_q[7:0];
                A_COUNT_H:  data_o = shadow_q;
                A_STATUS:   data_o = {6'b0, en_q, tf_q};
                default:    data_o = 8'h00;
            endcase
        end
    end

    assign irq_n_o = irq_n_q;

endmodule

// File: tb/tb_bank_timer.sv
// Directed testbench for bank_timer: bus reads/writes with hand-computed
// expected register values and interrupt timing.
module tb_bank_timer;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_n;

    int checks = 0;
    int errors = 0;
    logic rd_irq;

    bank_timer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cs_i    (cs),
        .R_W_n   (rw),
        .addr_i  (addr),
        .data_i  (din),
        .data_o  (dout),
        .irq_n_o (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; rw = 1'b1;
        $display("%0t wr  off=%0d data=%h", $time, a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a;
        #1;
        d = dout;
        rd_irq = irq_n;
        @(posedge clk);
        #1;
        cs = 1'b0;
        $display("%0t rd  off=%0d data=%h irq_n=%b", $time, a, d, rd_irq);
        check_eq(tag, {8'h00, d}, {8'h00, exp});
    endtask

    logic [2:0] rst_addr [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [7:0] rst_exp  [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    initial begin
        rst_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 3'd2; din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_irq", {15'b0, irq_n}, 16'h0001);
        check_eq("cs0_data", {8'h00, dout}, 16'h0000);

        for (int i = 0; i < 8; i++)
            rd_chk($sformatf("rst_off%0d", rst_addr[i]), rst_addr[i], rst_exp[i]);

        // write with cs low must be ignored
        @(negedge clk);
        cs = 1'b0; rw = 1'b0; addr = 3'd1; din = 8'h55;
        @(posedge clk);
        #1;
        rw = 1'b1;
        rd_chk("cs0_write", 3'd1, 8'h00);

        // continuous: period (3+1)*(1+1) = 8
        bus_wr(3'd1, 8'h01);
        bus_wr(3'd2, 8'h03);
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd0, 8'h0D);
        repeat (7) @(posedge clk);
        rd_chk("cont_e7", 3'd6, 8'h02);
        check_eq("cont_irq_e7", {15'b0, rd_irq}, 16'h0001);
        rd_chk("cont_e8", 3'd6, 8'h03);
        check_eq("cont_irq_e8", {15'b0, rd_irq}, 16'h0001);
        check_eq("cont_irq_e9", {15'b0, irq_n}, 16'h0000);
        bus_wr(3'd6, 8'h01);
        repeat (5) @(posedge clk);
        rd_chk("cont_e15", 3'd6, 8'h02);
        check_eq("cont_irq_e15", {15'b0, rd_irq}, 16'h0001);
        rd_chk("cont_e16", 3'd6, 8'h03);

        // collision: W1C lands on the edge that sets TF again
        repeat (6) @(posedge clk);
        bus_wr(3'd6, 8'h01);
        rd_chk("coll_tf", 3'd6, 8'h03);
        check_eq("coll_irq", {15'b0, rd_irq}, 16'h0000);
        check_eq("coll_irq_next", {15'b0, irq_n}, 16'h0000);
        bus_wr(3'd6, 8'h01);
        rd_chk("coll_clr", 3'd6, 8'h02);

        // coherent 16-bit read
        bus_wr(3'd1, 8'h00);
        bus_wr(3'd2, 8'h00);
        bus_wr(3'd3, 8'h01);
        bus_wr(3'd0, 8'h09);
        rd_chk("coh_lo", 3'd4, 8'h00);
        rd_chk("coh_hi", 3'd5, 8'h01);
        rd_chk("coh_lo2", 3'd4, 8'hFE);
        rd_chk("coh_hi2", 3'd5, 8'h00);
        bus_wr(3'd0, 8'h00);
        bus_wr(3'd6, 8'h01);
        rd_chk("coh_stat", 3'd6, 8'h00);

        // one-shot: TF three clocks after the LOAD edge
        bus_wr(3'd2, 8'h02);
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd0, 8'h0B);
        repeat (2) @(posedge clk);
        rd_chk("os_e2", 3'd6, 8'h02);
        rd_chk("os_e3", 3'd6, 8'h01);
        rd_chk("os_ctrl", 3'd0, 8'h02);
        rd_chk("os_cnt_lo", 3'd4, 8'h00);
        rd_chk("os_cnt_hi", 3'd5, 8'h00);
        bus_wr(3'd6, 8'h01);
        repeat (10) @(posedge clk);
        rd_chk("os_no_retrig", 3'd6, 8'h00);

        // freeze and resume
        bus_wr(3'd2, 8'h50);
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd0, 8'h09);
        repeat (4) @(posedge clk);
        bus_wr(3'd0, 8'h00);
        repeat (20) @(posedge clk);
        rd_chk("frz_lo", 3'd4, 8'h4B);
        rd_chk("frz_hi", 3'd5, 8'h00);
        bus_wr(3'd0, 8'h01);
        rd_chk("res_lo0", 3'd4, 8'h4B);
        rd_chk("res_lo1", 3'd4, 8'h4A);

        // interrupt masking
        bus_wr(3'd2, 8'h02);
        bus_wr(3'd0, 8'h0D);
        repeat (6) @(posedge clk);
        #1;
        check_eq("mask_irq_on", {15'b0, irq_n}, 16'h0000);
        bus_wr(3'd0, 8'h01);
        check_eq("mask_irq_lat", {15'b0, irq_n}, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("mask_irq_off", {15'b0, irq_n}, 16'h0001);
        rd_chk("mask_tf", 3'd6, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_timer.md
Name: bank_timer

Overview:
- Programmable 16-bit interval timer with maskable interrupt.
- Occupies one I/O bank of the $FE00–$FEFF window.
- Sits directly downstream of the address decoder: it consumes the decoder's chip select plus the CPU bus, and returns read data to the CPU read mux.
- Gives the 6502 a periodic or one-shot tick for scheduling and delays.

Parameters:
- RESET_RELOAD, 16'hFFFF, reset value of the reload register.
- RESET_PRESCALE, 8'h00, reset value of the prescaler register (divide by value+1).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- cs_i  input  1  chip select from the address decoder, active high.
- R_W_n  input  1  CPU read/write (1 = read, 0 = write).
- addr_i  input  3  register offset, CPU address bits [2:0].
- data_i  input  8  CPU write data.
- data_o  output  8  read data; combinational from registers; 8'h00 when cs_i = 0.
- irq_n_o  output  1  interrupt request, active low, level.

Behaviour:
- Bus access:
  - One clk_i cycle per access.
  - Write occurs at posedge when cs_i=1 and R_W_n=0.
  - Read side effects occur at posedge when cs_i=1 and R_W_n=1.
- Register map (offset: name):
  - 0 CTRL:
    - bit0 EN.
    - bit1 ONESHOT.
    - bit2 IE.
    - bit3 LOAD, write-only strobe, always reads 0.
    - bits7:4 read 0.
  - 1 PRESCALE: R/W.
  - 2 RELOAD_L, 3 RELOAD_H: R/W.
  - 4 COUNT_L: read returns count[7:0]; the read also latches count[15:8] into the shadow register.
  - 5 COUNT_H: read returns the shadow register.
  - 6 STATUS:
    - bit0 TF, write 1 to clear.
    - bit1 RUN (= EN), read-only.
  - 7: reads 0, writes ignored.
- Reset values:
  - CTRL = 0, TF = 0, shadow = 0.
  - count = RESET_RELOAD, prescale counter = RESET_PRESCALE.
  - PRESCALE = RESET_PRESCALE, RELOAD = RESET_RELOAD.
  - irq_n_o = 1.
  - Reset mid-count aborts immediately.
- Prescaler (8-bit down counter), active only while EN=1:
  - At 0, it generates a one-cycle tick and reloads PRESCALE.
  - Otherwise it decrements.
  - While EN=0, it holds.
- Counter, on tick:
  - If count ≠ 0, decrement.
  - If count = 0:
    - Set TF.
    - If ONESHOT=0, count <= RELOAD.
    - If ONESHOT=1, clear EN and hold count at 0.
  - Period = (RELOAD+1)·(PRESCALE+1) clocks.
- LOAD strobe (write of CTRL with bit3=1):
  - count <= RELOAD and prescaler <= PRESCALE on that edge.
  - The other CTRL bits take the written value in the same write.
  - LOAD overrides a simultaneous tick.
- Clearing EN freezes count and prescaler. Setting EN without LOAD resumes from the held values.
- Interrupt: irq_n_o = ~(TF & IE), registered output, one cycle after TF/IE change.
- Simultaneous events:
  - TF set by a tick and a W1C clear in the same cycle: the set wins, TF stays 1.
  - A write to RELOAD during a count does not affect the current count; it takes effect at the next reload or LOAD.
- No bus activity is needed for counting. cs_i=0 never alters registers.

Test Plan:
- Reset, then read all offsets → CTRL=00, PRESCALE=00, RELOAD=FF/FF, STATUS=00, offset 7=00; irq_n_o=1.
- Continuous timing:
  - Stimulus: PRESCALE=1, RELOAD=0x0003, CTRL=0x0D (EN|IE|LOAD).
  - Response: TF sets 8 clocks after the write edge; irq_n_o falls one cycle later.
  - Response: TF is re-set every 8 clocks after W1C clears.
- One-shot:
  - Stimulus: PRESCALE=0, RELOAD=0x0002, CTRL=0x0B.
  - Response: TF after 3 clocks; EN reads 0; count stays 0000; no further TF after clearing.
- Coherent read:
  - Stimulus: RELOAD=0x0100, PRESCALE=0, run; read COUNT_L when count=0x0100.
  - Response: COUNT_L=00; the following COUNT_H read returns 01 even though count is now 0x00FF.
- Collision: arrange the STATUS write of 0x01 on the same edge as the count-zero tick → TF remains 1, irq_n_o stays 0.
- Freeze and masking:
  - Clear EN mid-count → count holds for 20 clocks.
  - Set EN=1 (no LOAD) → counting resumes from the held value.
  - Set IE=0 with TF=1 → irq_n_o=1.
